// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  // One-hot grant vector implied by an arbiter state.
  function automatic logic [1:0] grant_of(input state_e st);
    case (st)
      GNT0:    grant_of = 2'b01;
      GNT1:    grant_of = 2'b10;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux2_sel.sv
// DW-bit 2:1 mux steered by the arbiter select; output forced to zero when idle.
module mux_rr_arbiter_mux2_sel #(
  parameter int DW = 8
) (
  input  logic          s,
  input  logic          busy,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    if (busy) y = s ? i1 : i0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter owning the select of a shared 2:1 mux.
// Optional grant statistics (C0/C1/forced) enabled by MUX_RR_ARBITER_STATS_EN.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          R0,
  input  logic          R1,
  input  logic [DW-1:0] I0,
  input  logic [DW-1:0] I1,
  output logic [1:0]    G,
  output logic          S,
  output logic [DW-1:0] out,
  output logic          busy
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]   C0,
  output logic [15:0]   C1,
  output logic          forced
`endif
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_e        state_q, state_d;
  logic [1:0]    g_q, g_d;
  logic          s_q, s_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic          at_max;
  logic          force_hand;
  logic          entry;

  assign at_max = (hold_q == HOLD_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; force_hand flags a MAX_HOLD preemption.
  always_comb begin
    state_d    = state_q;
    force_hand = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (R0 && !R1)      state_d = GNT0;
        else if (R1 && !R0) state_d = GNT1;
        else if (R0 && R1)  state_d = last_q ? GNT0 : GNT1;
      end
      GNT0: begin
        if (!R0) state_d = R1 ? GNT1 : IDLE;
        else if (R1 && at_max) begin
          state_d    = GNT1;
          force_hand = 1'b1;
        end
      end
      GNT1: begin
        if (!R1) state_d = R0 ? GNT0 : IDLE;
        else if (R0 && at_max) begin
          state_d    = GNT0;
          force_hand = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered grant/select follow the next state; S holds in IDLE.
  always_comb begin
    g_d = grant_of(state_d);
    s_d = s_q;
    if (state_d == GNT0) s_d = 1'b0;
    if (state_d == GNT1) s_d = 1'b1;
  end

  // Hold counter and last-served pointer
  always_comb begin
    entry  = (state_d != state_q) && (state_d != IDLE);
    hold_d = hold_q;
    last_d = last_q;
    if (state_d == IDLE)      hold_d = '0;
    else if (entry)           hold_d = HW'(1);
    else if (!at_max)         hold_d = hold_q + HW'(1);
    if (entry) last_d = (state_d == GNT1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q    <= GRANT_NONE;
      s_q    <= 1'b0;
      hold_q <= '0;
      last_q <= 1'b1;
    end else begin
      g_q    <= g_d;
      s_q    <= s_d;
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end

  assign G    = g_q;
  assign S    = s_q;
  assign busy = g_q[0] | g_q[1];

  mux_rr_arbiter_mux2_sel #(.DW(DW)) u_mux (
    .s    (s_q),
    .busy (busy),
    .i0   (I0),
    .i1   (I1),
    .y    (out)
  );

`ifdef MUX_RR_ARBITER_STATS_EN
  logic [15:0] c0_q, c0_d;
  logic [15:0] c1_q, c1_d;
  logic        forced_q, forced_d;

  always_comb begin
    c0_d     = c0_q;
    c1_d     = c1_q;
    forced_d = force_hand;
    if (entry && state_d == GNT0 && c0_q != 16'hFFFF) c0_d = c0_q + 16'd1;
    if (entry && state_d == GNT1 && c1_q != 16'hFFFF) c1_d = c1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q     <= '0;
      c1_q     <= '0;
      forced_q <= 1'b0;
    end else begin
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      forced_q <= forced_d;
    end
  end

  assign C0     = c0_q;
  assign C1     = c1_q;
  assign forced = forced_q;
`else
  logic unused_force;
  assign unused_force = force_hand;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DW=8, MAX_HOLD=4) with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       R0, R1;
  logic [7:0] I0, I1;
  logic [1:0] G;
  logic       S;
  logic [7:0] out;
  logic       busy;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [15:0] C0, C1;
  logic        forced;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .R0   (R0),
    .R1   (R1),
    .I0   (I0),
    .I1   (I1),
    .G    (G),
    .S    (S),
    .out  (out),
    .busy (busy)
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    .C0     (C0),
    .C1     (C1),
    .forced (forced)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and confirm the grant is never 11.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    assert (G !== 2'b11) else begin
      failures++;
      $error("FAIL g_not_11 observed=%0h expected=not 3", G);
    end
  endtask

  // Full output check for a given expected grant/select.
  task automatic chk_out(input string tag, input logic [1:0] eg, input logic es);
    logic [7:0] eo;
    eo = (eg == 2'b00) ? 8'h00 : (es ? I1 : I0);
    chk({tag, "_G"}, {30'd0, G}, {30'd0, eg});
    chk({tag, "_S"}, {31'd0, S}, {31'd0, es});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (eg != 2'b00)});
    chk({tag, "_out"}, {24'd0, out}, {24'd0, eo});
  endtask

  initial begin
    rst = 1'b1; R0 = 1'b1; R1 = 1'b1; I0 = 8'h3C; I1 = 8'hA5;

    // Reset held two cycles with both requests up
    step(); step();
    chk_out("reset", 2'b00, 1'b0);
`ifdef MUX_RR_ARBITER_STATS_EN
    chk("reset_C0", {16'd0, C0}, 32'd0);
    chk("reset_C1", {16'd0, C1}, 32'd0);
    chk("reset_forced", {31'd0, forced}, 32'd0);
`endif

    // Release: pointer=1 so requester 0 wins the tie
    rst = 1'b0;
    step();
    chk_out("rel_tie", 2'b01, 1'b0);
    R0 = 1'b0; R1 = 1'b0;
    step();
    chk_out("rel_idle", 2'b00, 1'b0);

    // Single requester held 10 cycles: no handoff, counter saturates
    R1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_out("single", 2'b10, 1'b1);
    end
    R1 = 1'b0;
    step();
    chk_out("single_drop", 2'b00, 1'b1);

    // Forced handoff: R0 first, then both held; 4-cycle alternation
    R0 = 1'b1;
    step();
    chk_out("fh_start", 2'b01, 1'b0);
    R1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("fh_g0", 2'b01, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      if (((k / 4) % 2) == 0) chk_out("fh_alt_g1", 2'b10, 1'b1);
      else                    chk_out("fh_alt_g0", 2'b01, 1'b0);
`ifdef MUX_RR_ARBITER_STATS_EN
      chk("fh_forced", {31'd0, forced}, {31'd0, ((k % 4) == 0)});
`endif
    end
    R0 = 1'b0; R1 = 1'b0;
    step();
    chk_out("fh_idle", 2'b00, 1'b0);

    // Voluntary handoff: drop R0 in cycle 2 of its grant
    R0 = 1'b1;
    step();
    chk_out("vol_g0a", 2'b01, 1'b0);
    R1 = 1'b1;
    step();
    chk_out("vol_g0b", 2'b01, 1'b0);
    R0 = 1'b0;
    step();
    chk_out("vol_g1", 2'b10, 1'b1);
    // Counter restarted at 1: three more GNT1 cycles before preemption
    R0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("vol_hold", 2'b10, 1'b1);
    end
    step();
    chk_out("vol_preempt", 2'b01, 1'b0);
    R0 = 1'b0; R1 = 1'b0;
    step();
    chk_out("vol_idle", 2'b00, 1'b0);

    // Make requester 1 the last served, then tie from IDLE twice
    R1 = 1'b1;
    step();
    chk_out("tie_prep", 2'b10, 1'b1);
    R1 = 1'b0;
    step();
    chk_out("tie_prep_idle", 2'b00, 1'b1);
    R0 = 1'b1; R1 = 1'b1;
    step();
    chk_out("tie_a", 2'b01, 1'b0);
    R0 = 1'b0; R1 = 1'b0;
    step();
    chk_out("tie_idle", 2'b00, 1'b0);
    R0 = 1'b1; R1 = 1'b1;
    step();
    chk_out("tie_b", 2'b10, 1'b1);

    // Mid-grant reset with hold counter at 3
    I0 = 8'h5A; I1 = 8'hC3;
    step(); step();
    chk_out("pre_rst", 2'b10, 1'b1);
    rst = 1'b1;
    step();
    chk_out("mid_rst", 2'b00, 1'b0);
`ifdef MUX_RR_ARBITER_STATS_EN
    chk("mid_rst_C0", {16'd0, C0}, 32'd0);
    chk("mid_rst_C1", {16'd0, C1}, 32'd0);
    chk("mid_rst_forced", {31'd0, forced}, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk_out("post_rst", 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
